// File: rtl/sonar_array.sv
`default_nettype none
// ============================================================================
// Module   : sonar_array
// Brief    : Round-robin multi-channel ultrasonic ranging controller with
//            echo-width measurement, timeout and single-entry result port.
// Revision : 1.0 - initial release
// ============================================================================
module sonar_array #(
  parameter int CHANNELS       = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 3_000_000,
  parameter int CNT_W          = 24,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode_cont,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trig,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_ch,
  output logic [CNT_W-1:0]    res_width,
  output logic                res_timeout,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] c_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_WIDTH_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CHANNELS-1:0] r_echo_s1, r_echo_s2, r_echo_d;
  logic [CHANNELS-1:0] r_mask, w_mask_nxt;
  logic                r_cont, w_cont_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_width, w_width_nxt, w_width_inc;
  logic                r_valid;
  logic [CH_W-1:0]     r_res_ch;
  logic [CNT_W-1:0]    r_res_width;
  logic                r_res_to;
  logic                r_overrun;

  logic [CH_W-1:0]     w_first, w_wrap, w_next;
  logic                w_has_next;
  logic                w_sel, w_sel_d, w_rise, w_fall;
  logic                w_pub, w_pub_to, w_clr_ov;
  logic [CNT_W-1:0]    w_pub_width;

  always_comb begin
    w_first = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (ch_mask[i]) w_first = CH_W'(i);
  end

  // Descending scan: the last hit is the lowest qualifying channel.
  always_comb begin
    w_wrap     = '0;
    w_next     = '0;
    w_has_next = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (r_mask[i]) w_wrap = CH_W'(i);
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next     = CH_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_sel       = r_echo_s2[r_ch];
  assign w_sel_d     = r_echo_d[r_ch];
  assign w_rise      = w_sel & ~w_sel_d;
  assign w_fall      = ~w_sel & w_sel_d;
  assign w_width_inc = (r_width == c_WIDTH_MAX) ? r_width : r_width + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cont_nxt  = r_cont;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_width_nxt = r_width;
    w_pub       = 1'b0;
    w_pub_to    = 1'b0;
    w_pub_width = r_width;
    w_clr_ov    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (ch_mask != '0)) begin
          w_state_nxt = S_TRIG;
          w_mask_nxt  = ch_mask;
          w_cont_nxt  = mode_cont;
          w_ch_nxt    = w_first;
          w_cnt_nxt   = '0;
          w_clr_ov    = 1'b1;
        end
      end
      S_TRIG: begin
        if (r_cnt == c_TRIG_LAST) begin
          w_state_nxt = S_WAIT_RISE;
          w_cnt_nxt   = '0;
          w_width_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_TO_LAST) begin
          w_pub       = 1'b1;
          w_pub_to    = 1'b1;
          w_pub_width = '0;
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else if (w_rise) begin
          // The rise cycle already has the echo high, so it counts.
          w_state_nxt = S_MEASURE;
          w_width_nxt = CNT_W'(1);
        end
      end
      S_MEASURE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_sel) w_width_nxt = w_width_inc;
        if (w_fall) begin
          w_pub       = 1'b1;
          w_pub_width = r_width;
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TO_LAST) begin
          w_pub       = 1'b1;
          w_pub_to    = 1'b1;
          w_pub_width = w_width_nxt;
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_cont) begin
            if (mode_cont) begin
              w_state_nxt = S_TRIG;
              w_ch_nxt    = w_has_next ? w_next : w_wrap;
            end
          end else if (w_has_next) begin
            w_state_nxt = S_TRIG;
            w_ch_nxt    = w_next;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_echo_s1   <= '0;
      r_echo_s2   <= '0;
      r_echo_d    <= '0;
      r_mask      <= '0;
      r_cont      <= 1'b0;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_width     <= '0;
      r_valid     <= 1'b0;
      r_res_ch    <= '0;
      r_res_width <= '0;
      r_res_to    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_mask    <= w_mask_nxt;
      r_cont    <= w_cont_nxt;
      r_ch      <= w_ch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_width   <= w_width_nxt;
      if (w_clr_ov) r_overrun <= 1'b0;
      // Single-entry result: a publish onto an unaccepted result is dropped.
      if (w_pub) begin
        if (!r_valid || res_ready) begin
          r_valid     <= 1'b1;
          r_res_ch    <= r_ch;
          r_res_width <= w_pub_width;
          r_res_to    <= w_pub_to;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && res_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    trig = '0;
    if (r_state == S_TRIG) trig[r_ch] = 1'b1;
  end

  assign busy        = (r_state != S_IDLE);
  assign res_valid   = r_valid;
  assign res_ch      = r_res_ch;
  assign res_width   = r_res_width;
  assign res_timeout = r_res_to;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sonar_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_array
// Brief    : Self-checking bench for sonar_array (result-register model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_array;

  localparam int c_TRIG = 5;
  localparam int c_TO   = 100;
  localparam int c_GAP  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode_cont;
  logic [3:0]  ch_mask;
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic [23:0] res_width;
  logic        res_timeout;
  logic        overrun;

  sonar_array #(
    .CHANNELS(4), .TRIG_CYCLES(c_TRIG), .TIMEOUT_CYCLES(c_TO),
    .GAP_CYCLES(c_GAP), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
    .ch_mask(ch_mask), .echo(echo), .trig(trig), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_width(res_width), .res_timeout(res_timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int ch;
    int w;
    bit to;
  } ev_t;

  ev_t  ev[$];
  int   cyc = 0;
  logic rdy_q = 1'b0;
  logic start_q = 1'b0;
  logic [3:0] mask_q = '0;

  always @(posedge clk) begin
    cyc++;
    rdy_q   = res_ready;
    start_q = start;
    mask_q  = ch_mask;
  end

  // Ping outcome from raw-echo timing relative to the trigger fall edge:
  // two sync stages put the synchronised rise at +d+2, the timeout fires
  // on the cycle whose count is TIMEOUT-1, results register one edge later.
  function automatic void model(input int d, input int len,
                                output int w, output bit to, output int pc);
    if (d < 0 || d + 2 >= c_TO - 1) begin
      w = 0; to = 1'b1; pc = c_TO;
    end else if (len >= 0 && d + len + 2 <= c_TO - 1) begin
      w = len; to = 1'b0; pc = d + len + 3;
    end else begin
      w = c_TO - d - 2; to = 1'b1; pc = c_TO;
    end
  endfunction

  bit       m_valid = 1'b0;
  bit       m_ov    = 1'b0;
  int       m_ch, m_w;
  bit       m_to;

  always @(negedge clk) begin
    bit  acc;
    ev_t e;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
      ev.delete();
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_ch", res_ch, 0);
      chk("rst_width", res_width, 0);
      chk("rst_timeout", res_timeout, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      acc = m_valid && rdy_q;
      if (start_q && mask_q != 4'd0) m_ov = 1'b0;
      if (ev.size() != 0 && ev[0].cyc == cyc) begin
        e = ev.pop_front();
        if (!m_valid || acc) begin
          m_valid = 1'b1; m_ch = e.ch; m_w = e.w; m_to = e.to;
        end else begin
          m_ov = 1'b1;
        end
      end else if (acc) begin
        m_valid = 1'b0;
      end
      chk("res_valid", res_valid, m_valid);
      if (m_valid) begin
        chk("res_ch", res_ch, m_ch);
        chk("res_width", res_width, m_w);
        chk("res_timeout", res_timeout, m_to);
      end
      chk("overrun", overrun, m_ov);
      chk("trig_onehot0", $onehot0(trig), 1);
      if (trig != 4'd0) chk("trig_implies_busy", busy, 1);
    end
  end

  task automatic do_start(input logic [3:0] m, input logic mc);
    ch_mask   = m;
    mode_cont = mc;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Waits for trig[ch], checks its length, queues the expected result and
  // drives the echo. len < 0 leaves the echo high on return.
  task automatic ping(input int ch, input int d, input int len, output int f);
    int n, w, pc;
    bit to;
    n = 0;
    while (!trig[ch] && n < 3000) begin @(negedge clk); n++; end
    if (!trig[ch]) begin
      chk("trig_seen", 0, 1);
      f = cyc;
      return;
    end
    n = 0;
    while (trig[ch] && n < 100) begin n++; @(negedge clk); end
    chk("trig_len", n, c_TRIG);
    f = cyc;
    model(d, len, w, to, pc);
    ev.push_back('{cyc: f + pc, ch: ch, w: w, to: to});
    if (d < 0) return;
    repeat (d) @(negedge clk);
    echo[ch] = 1'b1;
    if (len < 0) return;
    repeat (len) @(negedge clk);
    echo[ch] = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk("reached_idle", busy, 0);
  endtask

  initial begin
    int f, n;
    rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; ch_mask = '0;
    echo = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Start with empty mask is ignored
    do_start(4'b0000, 1'b0);
    repeat (4) @(negedge clk);
    chk("mask0_busy", busy, 0);
    chk("mask0_trig", trig, 0);

    // Single scan over ch0 and ch2
    do_start(4'b0101, 1'b0);
    chk("scan_busy", busy, 1);
    ping(0, 3, 20, f);
    wait_valid(n);
    chk("echo_lat0", n, 3);
    chk("scan_w0", res_width, 20);
    chk("scan_ch0", res_ch, 0);
    ping(2, 5, 37, f);
    wait_valid(n);
    chk("echo_lat2", n, 3);
    chk("scan_w2", res_width, 37);
    chk("scan_ch2", res_ch, 2);
    chk("scan_to2", res_timeout, 0);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("gap_to_idle", n, c_GAP);

    // Timeout without echo, then echo rising late and held
    do_start(4'b0010, 1'b0);
    ping(1, -1, 0, f);
    wait_valid(n);
    chk("timeout_lat", n, 100);
    chk("timeout_w", res_width, 0);
    chk("timeout_flag", res_timeout, 1);
    chk("timeout_ch", res_ch, 1);
    wait_idle(n);
    do_start(4'b0010, 1'b0);
    ping(1, 90, -1, f);
    wait_valid(n);
    chk("late_lat", n, 10);
    chk("late_w", res_width, 8);
    chk("late_flag", res_timeout, 1);
    repeat (2) @(negedge clk);
    echo[1] = 1'b0;
    wait_idle(n);

    // Backpressure: second result dropped, overrun sticky
    res_ready = 1'b0;
    do_start(4'b0011, 1'b0);
    ping(0, 2, 10, f);
    ping(1, 2, 12, f);
    wait_idle(n);
    chk("bp_held", res_valid, 1);
    chk("bp_ch", res_ch, 0);
    chk("bp_width", res_width, 10);
    chk("bp_overrun", overrun, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", res_valid, 0);
    do_start(4'b0001, 1'b0);
    chk("bp_ov_cleared", overrun, 0);
    ping(0, 2, 5, f);
    wait_valid(n);
    chk("bp_new_w", res_width, 5);
    wait_idle(n);

    // Continuous scan 0,3,0,3 then stop
    do_start(4'b1001, 1'b1);
    ping(0, 1, 4, f);
    ping(3, 2, 6, f);
    ping(0, 3, 8, f);
    ping(3, 4, 9, f);
    mode_cont = 1'b0;
    wait_idle(n);
    repeat (20) @(negedge clk);
    chk("cont_stopped_trig", trig, 0);
    chk("cont_stopped_busy", busy, 0);

    // Async reset in the middle of a measurement on ch2
    do_start(4'b0100, 1'b0);
    n = 0;
    while (!trig[2] && n < 50) begin @(negedge clk); n++; end
    while (trig[2] && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    echo[2] = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trig", trig, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    echo[2] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_start(4'b0100, 1'b0);
    ping(2, 4, 30, f);
    wait_valid(n);
    chk("restart_w", res_width, 30);
    chk("restart_ch", res_ch, 2);
    wait_idle(n);

    repeat (5) @(negedge clk);
    chk("events_drained", ev.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
